alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised, registered successor to the single-cycle datapath ALU. Operates on reg_in/acc_in.
//  Shifts run iteratively, one bit per cycle. Adds an iterative shift-add multiply (MUL).
//  Registers result, zero and carry flags behind a start/busy/done handshake.
//  Sits between the register file/accumulator and the writeback mux; the controller stalls on busy_out.
// PARAMETERS
//  WIDTH     8   datapath width in bits (>=4)
//  OPW       4   opcode width; ALU_Ops enum in definitions package is sized to OPW
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        synchronous, active-high
//  start_in   in   1        request; sampled only when busy_out==0
//  op_in      in   OPW      ALU_Ops: ADD SUB SLL SRL EQU GTR AND XOR MUL
//  reg_in     in   WIDTH    operand from register file (shift amount for SLL/SRL)
//  acc_in     in   WIDTH    operand from accumulator
//  busy_out   out  1        high while an accepted op is executing
//  done_out   out  1        one-cycle pulse: rslt_out/flags updated this cycle
//  rslt_out   out  WIDTH    registered result; held until next done_out
//  zero_out   out  1        registered: rslt_out==0 (SUB: reg_in==acc_in)
//  carry_out  out  1        registered: ADD carry-out, SUB borrow, MUL overflow, else 0
// BEHAVIOUR
//  Reset: state IDLE; busy_out=0, done_out=0, rslt_out=0, zero_out=0, carry_out=0.
//  Accept: start_in=1 and busy_out=0 at edge E0 -> op and operands latched; inputs then ignored.
//  start_in while busy_out=1 is dropped, not queued.
//  FSM: IDLE -> (single-cycle op) IDLE with done; IDLE -> SHIFT | MUL; SHIFT/MUL -> IDLE with done.
//  Latency (done_out=1 after edge En):
//   ADD SUB EQU GTR AND XOR, undefined op: n=1.
//   SLL/SRL by k: n=max(k,1) for 0<=k<WIDTH; k>=WIDTH: n=1, result 0.
//   MUL: n=WIDTH.
//  busy_out=1 from E1 until the edge raising done_out (single-cycle ops never raise busy_out).
//  Back-to-back: busy_out=0 in the done_out cycle, so start_in may be accepted at the same edge that clears done_out.
//  Arithmetic (WIDTH bits, unsigned):
//   ADD = reg+acc, carry=bit WIDTH.
//   SUB = reg-acc mod 2^WIDTH, carry=(reg<acc).
//   SLL = acc<<reg; SRL = acc>>reg (logical, zero fill).
//   EQU = (acc==reg); GTR = (reg>acc); result 1/0 in bit 0, upper bits 0.
//   AND/XOR bitwise.
//   MUL = low WIDTH bits of acc*reg, carry = OR of high WIDTH bits.
//  Undefined opcode: rslt=0, zero=1, carry=0, latency 1.
//  Outputs change only with done_out; during busy they hold the previous result.
//  reset mid-operation: abort at that edge, back to IDLE, all outputs to reset values, no done_out.
//  reset and start_in in the same cycle: reset wins.
// STRUCTURE
//  definitions package: ALU_Ops enum (OPW bits, MUL added) and alu_state_t {IDLE,SHIFT,MUL}.
//  Sub-module alu_iter_unit: shift/multiply engine with a counter, working register and product accumulator.
//   Interface: load, op, operands, finish strobe.
//  Top: FSM, operand latches, single-cycle combinational ops, output/flag registers.
// TESTING (WIDTH=8)
//  T1 ADD reg=0xF0 acc=0x20 -> done after E1, rslt=0x10, carry=1, zero=0, busy never high.
//  T2 SUB reg=0x33 acc=0x33 -> rslt=0x00, zero=1, carry=0. Then reg=0x01 acc=0x02 -> rslt=0xFF, carry=1.
//  T3 SLL acc=0x81 reg=3 -> busy 2 cycles, done at E3, rslt=0x08.
//     SRL reg=9 -> done at E1, rslt=0x00, zero=1.
//  T4 MUL acc=0x12 reg=0x10 -> done at E8, rslt=0x20, carry=1.
//     Then acc=7 reg=6 back-to-back in the done cycle -> rslt=0x2A, carry=0.
//  T5 MUL started, start_in pulsed at E3 with ADD -> ignored.
//     reset at E5 -> no done_out, all outputs 0 at E6.
//  T6 Undefined opcode 0xF -> rslt=0, zero=1, done at E1.
//     EQU acc=reg=0x5A -> rslt=0x01. GTR reg=0x10 acc=0x20 -> 0x00.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package alu_seq_pkg;

    localparam int unsigned OPW = 4;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_SLL = 4'd2,
        OP_SRL = 4'd3,
        OP_EQU = 4'd4,
        OP_GTR = 4'd5,
        OP_AND = 4'd6,
        OP_XOR = 4'd7,
        OP_MUL = 4'd8
    } alu_ops_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL
    } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the controller and the sequential ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
);
    logic             start_in;
    logic [OPW-1:0]   op_in;
    logic [WIDTH-1:0] reg_in;
    logic [WIDTH-1:0] acc_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] rslt_out;
    logic             zero_out;
    logic             carry_out;

    modport master (
        output start_in, op_in, reg_in, acc_in,
        input  busy_out, done_out, rslt_out, zero_out, carry_out
    );

    modport slave (
        input  start_in, op_in, reg_in, acc_in,
        output busy_out, done_out, rslt_out, zero_out, carry_out
    );
endinterface

// File: rtl/alu_seq_iter.sv
// Iterative engine: one shift bit or one shift-add multiply step per cycle.
// The load cycle already performs the first step; finish_c marks the final one.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  alu_ops_e         op,
    input  logic [WIDTH-1:0] reg_val,
    input  logic [WIDTH-1:0] acc_val,
    output logic             finish_c,
    output logic [WIDTH-1:0] result_c,
    output logic             ovf_c
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    logic             active_q, active_d;
    alu_ops_e         op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    work_q, work_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [PW-1:0]    work_step, prod_step;

    always_comb begin
        active_d  = active_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;

        // Work register holds the shifting value, or the multiplicand for MUL
        work_step = (op_q == OP_SRL) ? (work_q >> 1) : (work_q << 1);
        prod_step = prod_q + (mplier_q[0] ? work_q : '0);

        if (load) begin
            active_d = 1'b1;
            op_d     = op;
            if (op == OP_MUL) begin
                cnt_d    = CW'(WIDTH - 1);
                work_d   = PW'(acc_val) << 1;
                mplier_d = reg_val >> 1;
                prod_d   = reg_val[0] ? PW'(acc_val) : '0;
            end else begin
                cnt_d    = CW'(reg_val - WIDTH'(1));
                work_d   = (op == OP_SRL) ? PW'(acc_val >> 1) : PW'(acc_val) << 1;
                mplier_d = '0;
                prod_d   = '0;
            end
        end else if (active_q) begin
            work_d   = work_step;
            prod_d   = prod_step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) active_d = 1'b0;
        end
    end

    assign finish_c = active_q && (cnt_q == CW'(1));
    assign result_c = (op_q == OP_MUL) ? prod_step[WIDTH-1:0] : work_step[WIDTH-1:0];
    assign ovf_c    = (op_q == OP_MUL) && (|prod_step[PW-1:WIDTH]);

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            work_q   <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            active_q <= active_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU behind a start/busy/done handshake; long shifts and MUL
// run in alu_seq_iter, everything else completes one cycle after acceptance.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = alu_seq_pkg::OPW
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    alu_state_t       state_q, state_d;
    logic             pend_q, pend_d;
    alu_ops_e         op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rslt_q, rslt_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic [OPW-1:0]   op_raw;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] sc_rslt_c;
    logic             sc_carry_c;
    logic             shift_long_c;
    logic             iter_load_c;
    logic             iter_finish_c;
    logic [WIDTH-1:0] iter_result_c;
    logic             iter_ovf_c;

    assign op_raw = bus.op_in;

    // Single-cycle datapath; short and out-of-range shifts also resolve here
    always_comb begin
        sum_c      = {1'b0, a_q} + {1'b0, b_q};
        sc_rslt_c  = '0;
        sc_carry_c = 1'b0;
        case (op_q)
            OP_ADD: begin sc_rslt_c = sum_c[WIDTH-1:0]; sc_carry_c = sum_c[WIDTH]; end
            OP_SUB: begin sc_rslt_c = a_q - b_q;        sc_carry_c = (a_q < b_q); end
            OP_SLL: sc_rslt_c = b_q << a_q;
            OP_SRL: sc_rslt_c = b_q >> a_q;
            OP_EQU: sc_rslt_c = WIDTH'(b_q == a_q);
            OP_GTR: sc_rslt_c = WIDTH'(a_q > b_q);
            OP_AND: sc_rslt_c = a_q & b_q;
            OP_XOR: sc_rslt_c = a_q ^ b_q;
            default: sc_rslt_c = '0;
        endcase
        shift_long_c = ((op_q == OP_SLL) || (op_q == OP_SRL)) &&
                       (a_q >= WIDTH'(2)) && (a_q < WIDTH'(WIDTH));
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = 1'b0;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        done_d      = 1'b0;
        rslt_d      = rslt_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        iter_load_c = 1'b0;

        // Operand latch; a request already in flight blocks new ones
        if (bus.start_in && !busy_q && !pend_q && (state_q == ST_IDLE)) begin
            pend_d = 1'b1;
            op_d   = alu_ops_e'(op_raw);
            a_d    = bus.reg_in;
            b_d    = bus.acc_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    if (op_q == OP_MUL) begin
                        iter_load_c = 1'b1;
                        state_d     = ST_MUL;
                    end else if (shift_long_c) begin
                        iter_load_c = 1'b1;
                        state_d     = ST_SHIFT;
                    end else begin
                        done_d  = 1'b1;
                        rslt_d  = sc_rslt_c;
                        zero_d  = (sc_rslt_c == '0);
                        carry_d = sc_carry_c;
                    end
                end
            end
            ST_SHIFT, ST_MUL: begin
                if (iter_finish_c) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    rslt_d  = iter_result_c;
                    zero_d  = (iter_result_c == '0);
                    carry_d = iter_ovf_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (iter_load_c),
        .op       (op_q),
        .reg_val  (a_q),
        .acc_val  (b_q),
        .finish_c (iter_finish_c),
        .result_c (iter_result_c),
        .ovf_c    (iter_ovf_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rslt_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rslt_q  <= rslt_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign bus.busy_out  = busy_q;
    assign bus.done_out  = done_q;
    assign bus.rslt_out  = rslt_q;
    assign bus.zero_out  = zero_q;
    assign bus.carry_out = carry_q;
endmodule
